usr_seq_shifter: RTL and testbench
==================================

// Module: usr_seq_shifter
// PURPOSE
//  Parametrised universal shift register with a command handshake and multi-step shifting.
//  Accepts one command (hold, shift-right, shift-left or parallel-load) plus a shift
//  count, then performs one single-bit shift per clock until the count is exhausted.
//  Serves as the shared shift/serialise datapath for wider register banks.
// PARAMETERS
//  WIDTH      8       register width in bits, >= 2
//  MAX_SHIFT  WIDTH   largest shift count executed; shamt above it is clamped
//  CNT_W      $clog2(MAX_SHIFT+1)  localparam, width of shamt and the internal counter
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        block can accept a command (state IDLE)
//  mode       in   2        00 hold, 01 shift right (toward LSB), 10 shift left (toward MSB), 11 load
//  shamt      in   CNT_W    number of single-bit shifts, used only for modes 01/10
//  pload      in   WIDTH    parallel load data, used only for mode 11
//  ser_in_r   in   1        bit entering q[WIDTH-1] on each right shift
//  ser_in_l   in   1        bit entering q[0] on each left shift
//  q          out  WIDTH    register contents
//  busy       out  1        multi-cycle shift in progress (state SHIFT)
//  done       out  1        one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset (async, rst_n=0): q=0, state=IDLE, counter=0, busy=0, done=0, cmd_ready=1.
//  A command is accepted on any rising edge with cmd_valid && cmd_ready. mode, shamt and pload are sampled on that edge.
//  FSM: IDLE -> SHIFT when accepting mode 01/10 with shamt>=2; SHIFT -> IDLE when the last step is taken; all other accepts stay in IDLE.
//  Mode 11 (load): q<=pload on the accept edge. done=1 in the following cycle.
//  Mode 00 (hold): q unchanged. done=1 in the following cycle.
//  Mode 01/10 with shamt=0: handled exactly like hold.
//  Mode 01/10 with shamt=k (k>MAX_SHIFT is clamped to MAX_SHIFT):
//   - The first shift happens on the accept edge.
//   - One further shift happens per edge while in SHIFT, for k shifts in total.
//   - done pulses in the cycle after the k-th shift.
//   - busy=1 from the cycle after accept until the k-th shift edge.
//  Right shift: q <= {ser_in_r, q[WIDTH-1:1]}. Left shift: q <= {q[WIDTH-2:0], ser_in_l}.
//  Serial inputs are sampled live on every shift edge, not latched at accept.
//  cmd_ready=0 while busy. cmd_valid is ignored while busy; no queueing.
//  A new command may be accepted in the same cycle that done is high (back-to-back allowed).
//  Reset asserted mid-shift aborts immediately: q=0, state IDLE, no done pulse.
//  The count of remaining shifts never underflows; the counter is WIDTH-independent at CNT_W bits.
// CONFIGURATION
//  USR_SEQ_ROTATE_EN defined:
//   - Adds input port rot (1 bit), sampled at accept and held for the whole command.
//   - With rot=1, a right shift inserts the old q[0] and a left shift inserts the old q[WIDTH-1]; the ser_in_* inputs are ignored.
//   - With rot=0, behaviour is identical to the macro being undefined.
//  USR_SEQ_ROTATE_EN undefined: the rot port does not exist; behaviour is pure shift.
// STRUCTURE
//  Package usr_pkg:
//   - mode encoding constants MODE_HOLD/MODE_SHR/MODE_SHL/MODE_LOAD (2'b00..2'b11)
//   - FSM state typedef {IDLE, SHIFT}
//  Sub-module usr_core:
//   - WIDTH-bit register plus per-bit 4:1 next-state mux (hold/shr/shl/load)
//   - driven by an effective per-cycle mode from the control FSM in the top
//  The top holds the FSM, the shift counter, shamt clamping and the handshake logic.
// TESTING (WIDTH=8, MAX_SHIFT=8)
//  1 Reset: rst_n=0 for 2 cycles -> q=8'h00, cmd_ready=1, busy=0, done=0.
//  2 Load: mode=11, pload=8'hA5, one-cycle valid -> q=8'hA5 next edge; done pulses 1 cycle.
//  3 Shift right: load 8'h80, then mode=01, shamt=3, ser_in_r=0 -> q=8'h10 after 3 edges;
//    busy=1 for 2 cycles, done once, cmd_ready low until done.
//  4 Shift left with clamp: load 8'h01, then mode=10, shamt=15, ser_in_l=1
//    -> 8 shifts, q=8'hFF, done in the 9th cycle after accept.
//  5 Abort: start shift right shamt=6 on 8'hFF, pull rst_n low after 2 shifts
//    -> q=8'h00 immediately, no done; next load 8'h3C accepted normally.
//  6 Rotate (USR_SEQ_ROTATE_EN): load 8'h81, mode=01, rot=1, shamt=1 -> q=8'hC0;
//    then mode=10, shamt=2 -> q=8'h03. Also run with the macro undefined and check that the build passes.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the usr_seq_shifter slice: mode encodings and control FSM states.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/usr_seq_shifter_core.sv
// WIDTH-bit register with a per-bit hold/shift-right/shift-left/load next-state mux.
// Insert bits are supplied by the controller so serial and rotate sources stay outside.
module usr_core
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] pload_i,
  input  logic             ins_r_i,
  input  logic             ins_l_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    unique case (mode_i)
      MODE_SHR:  q_d = {ins_r_i, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], ins_l_i};
      MODE_LOAD: q_d = pload_i;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/usr_seq_shifter.sv
// Universal shift register with command handshake and multi-step shifting.
// Optional feature: define USR_SEQ_ROTATE_EN to add the rot input (rotate instead of serial fill).
module usr_seq_shifter
  import usr_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned MAX_SHIFT = WIDTH,
  localparam int unsigned CNT_W     = $clog2(MAX_SHIFT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] shamt,
  input  logic [WIDTH-1:0] pload,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
`ifdef USR_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic             done_q, done_d;
  logic [1:0]       core_mode;
  logic [CNT_W-1:0] shamt_c;
  logic             ins_r, ins_l;

  assign shamt_c = (shamt > CNT_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : shamt;

`ifdef USR_SEQ_ROTATE_EN
  logic rot_q, rot_d, rot_eff;
  // rot is taken live on the accept edge, then held from the latched copy.
  assign rot_eff = (state_q == IDLE) ? rot : rot_q;
  assign ins_r   = rot_eff ? q[0]       : ser_in_r;
  assign ins_l   = rot_eff ? q[WIDTH-1] : ser_in_l;
  assign rot_d   = (state_q == IDLE && cmd_valid) ? rot : rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rot_q <= 1'b0;
    else        rot_q <= rot_d;
  end
`else
  assign ins_r = ser_in_r;
  assign ins_l = ser_in_l;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    core_mode = MODE_HOLD;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d = mode;
          if (mode == MODE_LOAD) begin
            core_mode = MODE_LOAD;
            done_d    = 1'b1;
          end else if (mode == MODE_HOLD || shamt_c == '0) begin
            done_d = 1'b1;
          end else begin
            // First shift happens on the accept edge; the counter tracks what remains.
            core_mode = mode;
            if (shamt_c == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = SHIFT;
              cnt_d   = shamt_c - CNT_W'(1);
            end
          end
        end
      end
      SHIFT: begin
        core_mode = dir_q;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= MODE_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;

  usr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode_i  (core_mode),
    .pload_i (pload),
    .ins_r_i (ins_r),
    .ins_l_i (ins_l),
    .q_o     (q)
  );

endmodule

// File: tb/tb_usr_seq_shifter.sv
// Directed bench for usr_seq_shifter (WIDTH=8, MAX_SHIFT=8); covers rotate when USR_SEQ_ROTATE_EN is defined.
module tb_usr_seq_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] mode;
  logic [3:0] shamt;
  logic [7:0] pload;
  logic       ser_in_r;
  logic       ser_in_l;
  logic [7:0] q;
  logic       busy;
  logic       done;
`ifdef USR_SEQ_ROTATE_EN
  logic       rot;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  usr_seq_shifter #(
    .WIDTH(8),
    .MAX_SHIFT(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .mode      (mode),
    .shamt     (shamt),
    .pload     (pload),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
`ifdef USR_SEQ_ROTATE_EN
    .rot       (rot),
`endif
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge, then drop cmd_valid.
  task automatic issue(input logic [1:0] m, input logic [3:0] s, input logic [7:0] p);
    mode      = m;
    shamt     = s;
    pload     = p;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  int unsigned edges;
  bit          seen;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; mode = 2'b00; shamt = '0; pload = '0;
    ser_in_r = 1'b0; ser_in_l = 1'b0;
`ifdef USR_SEQ_ROTATE_EN
    rot = 1'b0;
`endif
    tick(); tick();
    check("rst_q", q, 8'h00);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();

    issue(2'b11, 4'd0, 8'hA5);
    check("load_q", q, 8'hA5);
    check("load_done", done, 1'b1);
    tick();
    check("load_done_pulse", done, 1'b0);

    issue(2'b00, 4'd5, 8'h00);
    check("hold_q", q, 8'hA5);
    check("hold_done", done, 1'b1);
    check("hold_busy", busy, 1'b0);
    tick();

    issue(2'b01, 4'd0, 8'h00);
    check("shr0_q", q, 8'hA5);
    check("shr0_done", done, 1'b1);
    tick();

    issue(2'b11, 4'd0, 8'h80); tick();
    ser_in_r = 1'b0;
    issue(2'b01, 4'd3, 8'h00);
    check("shr3_s1_q", q, 8'h40);
    check("shr3_s1_busy", busy, 1'b1);
    check("shr3_s1_ready", cmd_ready, 1'b0);
    check("shr3_s1_done", done, 1'b0);
    tick();
    check("shr3_s2_q", q, 8'h20);
    check("shr3_s2_busy", busy, 1'b1);
    tick();
    check("shr3_s3_q", q, 8'h10);
    check("shr3_s3_busy", busy, 1'b0);
    check("shr3_s3_done", done, 1'b1);
    check("shr3_s3_ready", cmd_ready, 1'b1);
    tick();
    check("shr3_done_pulse", done, 1'b0);

    ser_in_r = 1'b1;
    issue(2'b01, 4'd2, 8'h00);
    check("live_s1_q", q, 8'h88);
    ser_in_r = 1'b0;
    tick();
    check("live_s2_q", q, 8'h44);
    check("live_done", done, 1'b1);
    tick();

    issue(2'b10, 4'd1, 8'h00);
    check("shl1_q", q, 8'h88);
    check("shl1_busy", busy, 1'b0);
    check("shl1_done", done, 1'b1);
    tick();

    issue(2'b11, 4'd0, 8'h01); tick();
    ser_in_l = 1'b1;
    issue(2'b10, 4'd15, 8'h00);
    check("clamp_s1_q", q, 8'h03);
    // A load offered while busy must be ignored.
    mode = 2'b11; pload = 8'h00; cmd_valid = 1'b1;
    edges = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      edges++;
      if (done) seen = 1'b1;
    end
    cmd_valid = 1'b0;
    check("clamp_done_seen", seen, 1'b1);
    check("clamp_edges", edges, 7);
    check("clamp_q", q, 8'hFF);

    issue(2'b11, 4'd0, 8'hFF);
    check("b2b_q", q, 8'hFF);
    check("b2b_done", done, 1'b1);
    tick();

    ser_in_r = 1'b0;
    issue(2'b01, 4'd6, 8'h00);
    tick();
    check("abort_pre_q", q, 8'h3F);
    #2 rst_n = 1'b0;
    #1;
    check("abort_q", q, 8'h00);
    check("abort_busy", busy, 1'b0);
    tick(); tick();
    check("abort_done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    check("abort_ready", cmd_ready, 1'b1);
    issue(2'b11, 4'd0, 8'h3C);
    check("post_abort_q", q, 8'h3C);
    check("post_abort_done", done, 1'b1);
    tick();

`ifdef USR_SEQ_ROTATE_EN
    issue(2'b11, 4'd0, 8'h81); tick();
    ser_in_r = 1'b0; ser_in_l = 1'b0;
    rot = 1'b1;
    issue(2'b01, 4'd1, 8'h00);
    check("rotr_q", q, 8'hC0);
    tick();
    issue(2'b10, 4'd2, 8'h00);
    rot = 1'b0;
    tick();
    check("rotl_q", q, 8'h03);
    check("rotl_done", done, 1'b1);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
